// File: rtl/tlp_defs_pkg.sv
// Shared TLP constants: fmt/type codes, TRN remainder codes, notifier FSM encoding.
package tlp_defs_pkg;

    localparam int unsigned DW_W  = 32;
    localparam int unsigned FT_W  = 7;
    localparam int unsigned REM_W = 8;

    localparam logic [FT_W-1:0]  FMT_MWR32  = 7'b10_00000;
    localparam logic [FT_W-1:0]  FMT_MWR64  = 7'b11_00000;
    localparam logic [REM_W-1:0] TREM_ALL   = 8'h00;
    localparam logic [REM_W-1:0] TREM_UPPER = 8'h0F;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_REQ  = 5'b00010,
        ST_HDR0 = 5'b00100,
        ST_HDR1 = 5'b01000,
        ST_DATA = 5'b10000
    } tx_state_e;

    // Byte-reverse a DW so the payload lands little-endian on the wire.
    function automatic logic [DW_W-1:0] dw_swap(input logic [DW_W-1:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // First header DW pair of a one-DW memory write, FirstBE = F, LastBE = 0.
    function automatic logic [63:0] mwr_hdr0(input logic [FT_W-1:0] fmt_type,
                                             input logic [15:0] req_id,
                                             input logic [7:0] tag);
        return {1'b0, fmt_type, 8'h00, 16'h0001, req_id, tag, 8'h0F};
    endfunction

endpackage

// File: rtl/tx_completion_notifier.sv
// Turns huge-page-freed events into one-DW MWr TLPs on the TRN TX port.
// MWR32_SHORT_EN: send a 2-beat MWr32 when the completion address is below 4 GB.
module tx_completion_notifier
    import tlp_defs_pkg::*;
#(
    parameter int unsigned SEQ_W = 16
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [63:0] completed_buffer_address,
    input  logic [15:0] cfg_completer_id,
    input  logic        huge_page_free_1,
    input  logic        huge_page_free_2,
    output logic        tx_req,
    input  logic        tx_gnt,
    input  logic        trn_tbuf_av,
    input  logic        trn_tdst_rdy_n,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n
);

    tx_state_e        state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             pend_1_q, pend_1_d, pend_2_q, pend_2_d;
    logic             snap_1_q, snap_1_d, snap_2_q, snap_2_d;
    logic             short_q, short_d;
    logic             tx_req_d, tsof_n_d, teof_n_d, tsrc_rdy_n_d;
    logic [63:0]      td_d;
    logic [7:0]       trem_n_d;

    logic             use_short_c;
    logic [63:0]      addr_dw_c;
    logic [DW_W-1:0]  payload_le_c;
    logic             beat_acc_c;

    assign addr_dw_c    = completed_buffer_address & ~64'h3;
    assign payload_le_c = dw_swap({16'(seq_q), 14'b0, snap_2_q, snap_1_q});
    assign beat_acc_c   = ~trn_tdst_rdy_n;

`ifdef MWR32_SHORT_EN
    assign use_short_c = (completed_buffer_address[63:32] == 32'h0);
`else
    assign use_short_c = 1'b0;
`endif

    // The block never discontinues a TLP.
    assign trn_tsrc_dsc_n = 1'b1;

    // Event latch, FSM and beat mux; every output register has its next value here.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        pend_1_d     = pend_1_q | huge_page_free_1;
        pend_2_d     = pend_2_q | huge_page_free_2;
        snap_1_d     = snap_1_q;
        snap_2_d     = snap_2_q;
        short_d      = short_q;
        tx_req_d     = tx_req;
        td_d         = trn_td;
        trem_n_d     = trn_trem_n;
        tsof_n_d     = trn_tsof_n;
        teof_n_d     = trn_teof_n;
        tsrc_rdy_n_d = trn_tsrc_rdy_n;

        unique case (state_q)
            ST_IDLE: begin
                if ((pend_1_q | pend_2_q) && (completed_buffer_address != 64'h0)) begin
                    state_d  = ST_REQ;
                    tx_req_d = 1'b1;
                    snap_1_d = pend_1_q;
                    snap_2_d = pend_2_q;
                    // A pulse on the snapshot edge rides in the next TLP.
                    pend_1_d = huge_page_free_1;
                    pend_2_d = huge_page_free_2;
                end
            end
            ST_REQ: begin
                if (tx_gnt && trn_tbuf_av) begin
                    state_d      = ST_HDR0;
                    short_d      = use_short_c;
                    td_d         = mwr_hdr0(use_short_c ? FMT_MWR32 : FMT_MWR64,
                                            cfg_completer_id, 8'(seq_q));
                    trem_n_d     = TREM_ALL;
                    tsof_n_d     = 1'b0;
                    teof_n_d     = 1'b1;
                    tsrc_rdy_n_d = 1'b0;
                end
            end
            ST_HDR0: begin
                if (beat_acc_c) begin
                    state_d  = ST_HDR1;
                    tsof_n_d = 1'b1;
                    if (short_q) begin
                        td_d     = {addr_dw_c[31:0], payload_le_c};
                        teof_n_d = 1'b0;
                    end else begin
                        td_d     = addr_dw_c;
                    end
                end
            end
            ST_HDR1: begin
                if (beat_acc_c) begin
                    if (short_q) begin
                        state_d      = ST_IDLE;
                        tx_req_d     = 1'b0;
                        seq_d        = seq_q + SEQ_W'(1);
                        td_d         = 64'h0;
                        trem_n_d     = TREM_ALL;
                        teof_n_d     = 1'b1;
                        tsrc_rdy_n_d = 1'b1;
                    end else begin
                        state_d  = ST_DATA;
                        td_d     = {payload_le_c, 32'h0};
                        trem_n_d = TREM_UPPER;
                        teof_n_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (beat_acc_c) begin
                    state_d      = ST_IDLE;
                    tx_req_d     = 1'b0;
                    seq_d        = seq_q + SEQ_W'(1);
                    td_d         = 64'h0;
                    trem_n_d     = TREM_ALL;
                    teof_n_d     = 1'b1;
                    tsrc_rdy_n_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            seq_q          <= '0;
            pend_1_q       <= 1'b0;
            pend_2_q       <= 1'b0;
            snap_1_q       <= 1'b0;
            snap_2_q       <= 1'b0;
            short_q        <= 1'b0;
            tx_req         <= 1'b0;
            trn_td         <= 64'h0;
            trn_trem_n     <= TREM_ALL;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            pend_1_q       <= pend_1_d;
            pend_2_q       <= pend_2_d;
            snap_1_q       <= snap_1_d;
            snap_2_q       <= snap_2_d;
            short_q        <= short_d;
            tx_req         <= tx_req_d;
            trn_td         <= td_d;
            trn_trem_n     <= trem_n_d;
            trn_tsof_n     <= tsof_n_d;
            trn_teof_n     <= teof_n_d;
            trn_tsrc_rdy_n <= tsrc_rdy_n_d;
        end
    end

endmodule

// File: tb/tb_tx_completion_notifier.sv
// Directed bench for tx_completion_notifier; a 3-bit-sequence twin exercises counter wrap.
module tb_tx_completion_notifier;

    logic        trn_clk = 1'b0;
    logic        reset_n;
    logic [63:0] completed_buffer_address;
    logic [15:0] cfg_completer_id;
    logic        huge_page_free_1, huge_page_free_2;
    logic        tx_req, tx_gnt, trn_tbuf_av, trn_tdst_rdy_n;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;

    logic        s_tx_req, s_tx_gnt;
    logic [63:0] s_td;
    logic [7:0]  s_trem_n;
    logic        s_tsof_n, s_teof_n, s_tsrc_rdy_n, s_tsrc_dsc_n;

    // Zero-wait arbiter: grant follows request.
    assign tx_gnt   = tx_req;
    assign s_tx_gnt = s_tx_req;

    always #5 trn_clk = ~trn_clk;

    tx_completion_notifier dut (
        .trn_clk(trn_clk), .reset_n(reset_n),
        .completed_buffer_address(completed_buffer_address),
        .cfg_completer_id(cfg_completer_id),
        .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
        .tx_req(tx_req), .tx_gnt(tx_gnt), .trn_tbuf_av(trn_tbuf_av),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
        .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n)
    );

    tx_completion_notifier #(.SEQ_W(3)) dut_small (
        .trn_clk(trn_clk), .reset_n(reset_n),
        .completed_buffer_address(completed_buffer_address),
        .cfg_completer_id(cfg_completer_id),
        .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
        .tx_req(s_tx_req), .tx_gnt(s_tx_gnt), .trn_tbuf_av(trn_tbuf_av),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_td(s_td), .trn_trem_n(s_trem_n),
        .trn_tsof_n(s_tsof_n), .trn_teof_n(s_teof_n),
        .trn_tsrc_rdy_n(s_tsrc_rdy_n), .trn_tsrc_dsc_n(s_tsrc_dsc_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] beats [3];
    logic [63:0] s_hdr0, s_last;
    logic [7:0]  last_rem;
    int          nb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] le32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic pulse(input logic p1, input logic p2);
        huge_page_free_1 = p1;
        huge_page_free_2 = p2;
        tick();
        huge_page_free_1 = 1'b0;
        huge_page_free_2 = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Wait for SOF, then accept beats until EOF, optionally stalling one beat.
    task automatic get_tlp(input string tag, input int stall_beat, input int stall_cyc);
        int          t;
        logic [63:0] held;
        logic        eof_at, eof_last;
        t        = 0;
        nb       = 0;
        last_rem = 8'h00;
        eof_last = 1'b1;
        for (int i = 0; i < 3; i++) beats[i] = 64'h0;
        trn_tdst_rdy_n = 1'b0;
        while (trn_tsof_n !== 1'b0 && t < 40) begin
            tick();
            t++;
        end
        if (trn_tsof_n !== 1'b0) begin
            check({tag, "_sof_timeout"}, 64'(trn_tsof_n), 64'd0);
            return;
        end
        for (int b = 0; b < 3; b++) begin
            if (trn_tsrc_rdy_n !== 1'b0) begin
                check({tag, "_src_rdy_gap"}, 64'(trn_tsrc_rdy_n), 64'd0);
                return;
            end
            held   = trn_td;
            eof_at = trn_teof_n;
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    trn_tdst_rdy_n = 1'b1;
                    tick();
                    check({tag, "_stall_td"}, trn_td, held);
                    check({tag, "_stall_src_rdy"}, 64'(trn_tsrc_rdy_n), 64'd0);
                    check({tag, "_stall_eof"}, 64'(trn_teof_n), 64'(eof_at));
                end
                trn_tdst_rdy_n = 1'b0;
            end
            beats[b] = trn_td;
            last_rem = trn_trem_n;
            eof_last = trn_teof_n;
            if (b == 0) s_hdr0 = s_td;
            s_last = s_td;
            nb     = b + 1;
            tick();
            if (eof_last == 1'b0) return;
        end
        check({tag, "_no_eof"}, 64'(eof_last), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_req;
        reset_n                  = 1'b0;
        completed_buffer_address = 64'h0000_0001_2345_6780;
        cfg_completer_id         = 16'h0100;
        huge_page_free_1         = 1'b0;
        huge_page_free_2         = 1'b0;
        trn_tbuf_av              = 1'b1;
        trn_tdst_rdy_n           = 1'b0;
        tick();
        tick();
        check("rst_tx_req",   64'(tx_req),         64'd0);
        check("rst_sof",      64'(trn_tsof_n),     64'd1);
        check("rst_eof",      64'(trn_teof_n),     64'd1);
        check("rst_src_rdy",  64'(trn_tsrc_rdy_n), 64'd1);
        check("rst_dsc",      64'(trn_tsrc_dsc_n), 64'd1);
        check("rst_td",       trn_td,              64'd0);
        check("rst_trem",     64'(trn_trem_n),     64'h00);
        reset_n = 1'b1;
        tick();

        // Page-1 free: latency and 3-beat MWr64 content
        pulse(1'b1, 1'b0);
        check("t1_req_n",   64'(tx_req),     64'd0);
        tick();
        check("t1_req_n1",  64'(tx_req),     64'd1);
        check("t1_sof_n1",  64'(trn_tsof_n), 64'd1);
        tick();
        check("t1_sof_n2",  64'(trn_tsof_n), 64'd0);
        get_tlp("t1", -1, 0);
        check("t1_nbeats",  64'(nb),            64'd3);
        check("t1_hdr0",    beats[0],           64'h6000_0001_0100_000F);
        check("t1_hdr1",    beats[1],           64'h0000_0001_2345_6780);
        check("t1_data",    64'(beats[2][63:32]), 64'h0100_0000);
        check("t1_rem",     64'(last_rem),      64'h0F);
        check("t1_req_end", 64'(tx_req),        64'd0);
        check("t1_src_end", 64'(trn_tsrc_rdy_n), 64'd1);

        // Both pages at once, then page 2 on the snapshot edge
        do_reset();
        huge_page_free_1 = 1'b1;
        huge_page_free_2 = 1'b1;
        tick();
        huge_page_free_1 = 1'b0;
        tick();
        huge_page_free_2 = 1'b0;
        get_tlp("t2a", -1, 0);
        check("t2a_tag",  64'(beats[0][15:0]),   64'h000F);
        check("t2a_data", 64'(beats[2][63:32]), 64'(le32(32'h0000_0003)));
        get_tlp("t2b", -1, 0);
        check("t2b_tag",  64'(beats[0][15:0]),   64'h010F);
        check("t2b_data", 64'(beats[2][63:32]), 64'h0200_0100);

        // No TX buffer holds the request; HDR1 stalled for 4 cycles
        trn_tbuf_av = 1'b0;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("t3_req_wait", 64'(tx_req),     64'd1);
        check("t3_sof_wait", 64'(trn_tsof_n), 64'd1);
        trn_tbuf_av = 1'b1;
        get_tlp("t3", 1, 4);
        check("t3_nbeats", 64'(nb),              64'd3);
        check("t3_hdr1",   beats[1],             64'h0000_0001_2345_6780);
        check("t3_data",   64'(beats[2][63:32]), 64'h0100_0200);

        // Zero address blocks the notification until programmed
        completed_buffer_address = 64'h0;
        pulse(1'b1, 1'b0);
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            saw_req = saw_req | tx_req;
            tick();
        end
        check("t4_no_req", 64'(saw_req), 64'd0);
        completed_buffer_address = 64'h0000_0000_0000_1000;
        get_tlp("t4", -1, 0);
`ifdef MWR32_SHORT_EN
        check("t4_nbeats", 64'(nb),              64'd2);
        check("t4_fmt",    64'(beats[0][63:56]), 64'h40);
        check("t4_hdr1",   beats[1],             64'h0000_1000_0100_0300);
        check("t4_rem",    64'(last_rem),        64'h00);
`else
        check("t4_nbeats", 64'(nb),              64'd3);
        check("t4_fmt",    64'(beats[0][63:56]), 64'h60);
        check("t4_hdr1",   beats[1],             64'h0000_0000_0000_1000);
        check("t4_data",   64'(beats[2][63:32]), 64'h0100_0300);
        check("t4_rem",    64'(last_rem),        64'h0F);
`endif

        // Reset while the DATA beat is on the bus
        completed_buffer_address = 64'h0000_0001_2345_6780;
        pulse(1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check("t5_in_data", 64'(trn_teof_n), 64'd0);
        trn_tdst_rdy_n = 1'b1;
        reset_n        = 1'b0;
        #1;
        check("t5_async_src", 64'(trn_tsrc_rdy_n), 64'd1);
        check("t5_async_req", 64'(tx_req),         64'd0);
        check("t5_async_td",  trn_td,              64'd0);
        tick();
        check("t5_next_src",  64'(trn_tsrc_rdy_n), 64'd1);
        check("t5_next_eof",  64'(trn_teof_n),     64'd1);
        reset_n        = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        tick();
        pulse(1'b1, 1'b0);
        get_tlp("t5", -1, 0);
        check("t5_seq_tag",  64'(beats[0][15:0]),   64'h000F);
        check("t5_seq_data", 64'(beats[2][63:32]), 64'h0100_0000);

        // Sequence wrap, shown on the 3-bit twin alongside the 16-bit counter
        do_reset();
        for (int i = 0; i < 9; i++) begin
            pulse(1'b1, 1'b0);
            get_tlp("t6", -1, 0);
            check("t6_small_tag", 64'(s_hdr0[15:8]),  64'(i % 8));
            check("t6_main_tag",  64'(beats[0][15:8]), 64'(i));
        end
        check("t6_small_wrap_data", 64'(s_last[63:32]),   64'h0100_0000);
        check("t6_main_data",       64'(beats[2][63:32]), 64'h0100_0800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
